// File: rtl/pe2ddr_mc_config.sv
// rtl/pe2ddr_mc_config.sv - instruction-driven write-back sequencer from PE groups to DDR write channels
// Each group launches one strided burst per enabled channel and waits for all of them to finish.
module pe2ddr_mc_config #(
    parameter int PE_NUM     = 32,
    parameter int PE_PER_GRP = 4,
    parameter int DDR_CH     = 2,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8,
    parameter int GRP_NUM    = PE_NUM / PE_PER_GRP,
    parameter int GRP_W      = $clog2(GRP_NUM + 1),
    parameter int INST_W     = 3*DDR_ADDR_W + 2*BURST_W + GRP_W
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_pooling,
    input  logic [DDR_CH-1:0]              i_ch_mask,
    input  logic [INST_W-1:0]              i_ins,
    input  logic                           i_ins_valid,
    output logic                           o_ins_ready,
    output logic [GRP_W-1:0]               o_rd_sel,
    output logic                           o_busy,
    output logic [DDR_CH-1:0]              o_ddr_start,
    input  logic [DDR_CH-1:0]              i_ddr_done,
    output logic [DDR_CH*DDR_ADDR_W-1:0]   o_ddr_st_addr,
    output logic [DDR_CH*BURST_W-1:0]      o_ddr_burst,
    output logic [DDR_CH*DDR_ADDR_W-1:0]   o_ddr_step,
    output logic [DDR_CH*BURST_W-1:0]      o_ddr_burst_num
);

    localparam int OFF_BURST  = DDR_ADDR_W;
    localparam int OFF_STEP   = OFF_BURST + BURST_W;
    localparam int OFF_NUM    = OFF_STEP + DDR_ADDR_W;
    localparam int OFF_STRIDE = OFF_NUM + BURST_W;
    localparam int OFF_LAST   = OFF_STRIDE + DDR_ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                         r_state;
    state_t                         w_next_state;

    logic                           r_ins_ready;
    logic                           r_busy;
    logic [GRP_W-1:0]               r_grp;
    logic [GRP_W-1:0]               r_last_grp;
    logic [DDR_CH-1:0]              r_mask;
    logic [DDR_CH-1:0]              r_done;
    logic [DDR_ADDR_W-1:0]          r_stride;
    logic [DDR_ADDR_W-1:0]          r_next_addr;
    logic [DDR_ADDR_W-1:0]          r_step;
    logic [BURST_W-1:0]             r_burst;
    logic [BURST_W-1:0]             r_burst_num;
    logic [DDR_CH*DDR_ADDR_W-1:0]   r_st_addr;

    logic [DDR_ADDR_W-1:0]          w_ins_base;
    logic [BURST_W-1:0]             w_ins_burst;
    logic [DDR_ADDR_W-1:0]          w_ins_step;
    logic [BURST_W-1:0]             w_ins_num;
    logic [DDR_ADDR_W-1:0]          w_ins_stride;
    logic [GRP_W-1:0]               w_ins_last;
    logic [GRP_W-1:0]               w_last_clamped;
    logic [BURST_W-1:0]             w_half_burst;
    logic [BURST_W-1:0]             w_burst_eff;

    logic                           w_accept;
    logic                           w_all_done;
    logic                           w_advance;
    logic                           w_load;
    logic [DDR_ADDR_W-1:0]          w_src_base;
    logic [DDR_ADDR_W-1:0]          w_src_stride;
    logic [DDR_ADDR_W-1:0]          w_acc;
    logic [DDR_ADDR_W-1:0]          w_next_grp_addr;
    logic [DDR_CH*DDR_ADDR_W-1:0]   w_addr_flat;

    assign w_ins_base   = i_ins[DDR_ADDR_W-1:0];
    assign w_ins_burst  = i_ins[OFF_BURST +: BURST_W];
    assign w_ins_step   = i_ins[OFF_STEP +: DDR_ADDR_W];
    assign w_ins_num    = i_ins[OFF_NUM +: BURST_W];
    assign w_ins_stride = i_ins[OFF_STRIDE +: DDR_ADDR_W];
    assign w_ins_last   = i_ins[OFF_LAST +: GRP_W];

    assign w_last_clamped = (w_ins_last >= GRP_W'(GRP_NUM)) ? GRP_W'(GRP_NUM - 1) : w_ins_last;
    assign w_half_burst   = w_ins_burst >> 1;
    assign w_burst_eff    = !i_pooling ? w_ins_burst :
                            (w_half_burst == '0) ? BURST_W'(1) : w_half_burst;

    assign w_accept   = (r_state == S_IDLE) && r_ins_ready && i_ins_valid;
    assign w_all_done = &(r_done | i_ddr_done);
    assign w_advance  = (r_state == S_WAIT) && w_all_done && (r_grp != r_last_grp);
    assign w_load     = w_accept || w_advance;

    // On accept the first group is addressed straight from the instruction word.
    assign w_src_base   = w_accept ? w_ins_base : r_next_addr;
    assign w_src_stride = w_accept ? w_ins_stride : r_stride;

    always_comb begin
        w_addr_flat = '0;
        w_acc       = w_src_base;
        for (int c = 0; c < DDR_CH; c++) begin
            w_addr_flat[c*DDR_ADDR_W +: DDR_ADDR_W] = w_acc;
            w_acc = w_acc + w_src_stride;
        end
        w_next_grp_addr = w_acc;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_ddr_start  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_ddr_start  = r_mask;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_all_done) begin
                    w_next_state = (r_grp == r_last_grp) ? S_IDLE : S_ISSUE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ins_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_grp       <= '0;
            r_last_grp  <= '0;
            r_mask      <= '0;
            r_done      <= '0;
            r_stride    <= '0;
            r_next_addr <= '0;
            r_step      <= '0;
            r_burst     <= '0;
            r_burst_num <= '0;
            r_st_addr   <= '0;
        end else begin
            r_ins_ready <= (w_next_state == S_IDLE);
            r_busy      <= (w_next_state != S_IDLE);

            if (w_accept) begin
                r_grp       <= '0;
                r_last_grp  <= w_last_clamped;
                r_mask      <= i_ch_mask;
                r_stride    <= w_ins_stride;
                r_step      <= w_ins_step;
                r_burst     <= w_burst_eff;
                r_burst_num <= w_ins_num;
            end else if (w_advance) begin
                r_grp <= r_grp + GRP_W'(1);
            end

            if (w_load) begin
                r_st_addr   <= w_addr_flat;
                r_next_addr <= w_next_grp_addr;
            end

            // Masked channels start out complete so they never hold up a group.
            if (r_state == S_ISSUE) begin
                r_done <= ~r_mask;
            end else if (r_state == S_WAIT) begin
                r_done <= r_done | i_ddr_done;
            end
        end
    end

    assign o_ins_ready     = r_ins_ready;
    assign o_busy          = r_busy;
    assign o_rd_sel        = r_grp;
    assign o_ddr_st_addr   = r_st_addr;
    assign o_ddr_burst     = {DDR_CH{r_burst}};
    assign o_ddr_step      = {DDR_CH{r_step}};
    assign o_ddr_burst_num = {DDR_CH{r_burst_num}};

endmodule
